// File: rtl/dsm_ctrl_pkg.sv
// Shared definitions for the DSM transmit-chain control blocks.
//   sweep_state_t : states of the frequency-sweep sequencer
//   DSM_*_WIDTH   : default widths, kept in step with the dsm_core instantiation
package dsm_ctrl_pkg;

  localparam int DSM_STEP_WIDTH  = 32;  // ACC_FRAC_WIDTH + ACC_INT_WIDTH
  localparam int DSM_DWELL_WIDTH = 16;
  localparam int DSM_NPTS_WIDTH  = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DWELL = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage

// File: rtl/dsm_dwell_timer.sv
// Loadable down-counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_value into the counter (wins over counting)
//   load_value  : interval length in cycles
//   expired     : high during the final cycle of a loaded interval
// A load of N keeps the timer running for N cycles; expired is high in the
// last of them. A load of 0 never expires, so callers skip the timer instead.
module dsm_dwell_timer
  import dsm_ctrl_pkg::*;
#(
  parameter int WIDTH = DSM_DWELL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign expired = (count_reg == WIDTH'(1));

endmodule

// File: rtl/dsm_sweep_ctrl.sv
// Frequency-sweep sequencer feeding nco_step beats to the I/Q NCO pair.
//   aclk, arst_n        : clock, asynchronous active-low reset
//   cfg_*               : sweep setup, captured into shadow registers on start
//   start, abort        : level-sampled control requests
//   m_axis_step_*       : step stream to the NCOs (tvalid/tdata held until tready)
//   dither_enable       : chain dither, updated only on an accepted start
//   busy, done          : status; done pulses one cycle at sweep completion
//   point_idx           : index of the point currently issued or dwelling
module dsm_sweep_ctrl
  import dsm_ctrl_pkg::*;
#(
  parameter int STEP_WIDTH  = DSM_STEP_WIDTH,
  parameter int DWELL_WIDTH = DSM_DWELL_WIDTH,
  parameter int NPTS_WIDTH  = DSM_NPTS_WIDTH
) (
  input  logic                   aclk,
  input  logic                   arst_n,
  input  logic [STEP_WIDTH-1:0]  cfg_start_step,
  input  logic [STEP_WIDTH-1:0]  cfg_delta_step,
  input  logic [NPTS_WIDTH-1:0]  cfg_num_points,
  input  logic [DWELL_WIDTH-1:0] cfg_dwell,
  input  logic                   cfg_dither,
  input  logic                   cfg_loop,
  input  logic                   start,
  input  logic                   abort,
  output logic [STEP_WIDTH-1:0]  m_axis_step_tdata,
  output logic                   m_axis_step_tvalid,
  input  logic                   m_axis_step_tready,
  output logic                   dither_enable,
  output logic                   busy,
  output logic                   done,
  output logic [NPTS_WIDTH-1:0]  point_idx
);

  sweep_state_t state_reg, state_next;

  logic [STEP_WIDTH-1:0]  sh_start_reg;
  logic [STEP_WIDTH-1:0]  sh_delta_reg;
  logic [NPTS_WIDTH-1:0]  sh_num_reg;
  logic [DWELL_WIDTH-1:0] sh_dwell_reg;
  logic                   sh_loop_reg;

  logic [STEP_WIDTH-1:0]  step_reg;
  logic [NPTS_WIDTH-1:0]  point_idx_reg;
  logic                   dither_reg;
  // Abort seen while a beat is stalled; the beat must still complete.
  logic                   abort_pend_reg, abort_pend_next;

  logic load_cfg, advance, reload, timer_load, timer_expired, last_point;

  assign last_point = (point_idx_reg == sh_num_reg - NPTS_WIDTH'(1));

  dsm_dwell_timer #(.WIDTH(DWELL_WIDTH)) u_dwell_timer (
    .clk        (aclk),
    .rst_n      (arst_n),
    .load       (timer_load),
    .load_value (sh_dwell_reg),
    .expired    (timer_expired)
  );

  // State register
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg      <= IDLE;
      abort_pend_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      abort_pend_reg <= abort_pend_next;
    end
  end

  // Next-state and datapath strobes
  always_comb begin
    state_next      = state_reg;
    abort_pend_next = abort_pend_reg;
    load_cfg        = 1'b0;
    advance         = 1'b0;
    reload          = 1'b0;
    timer_load      = 1'b0;
    case (state_reg)
      IDLE: begin
        abort_pend_next = 1'b0;
        if (start && !abort) begin
          load_cfg   = 1'b1;
          state_next = (cfg_num_points == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (m_axis_step_tready) begin
          if (abort || abort_pend_reg) begin
            state_next = IDLE;
          end else if (sh_dwell_reg != '0) begin
            timer_load = 1'b1;
            state_next = DWELL;
          end else if (last_point) begin
            // Zero dwell: take the dwell-exit path straight away.
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = ISSUE;
          end
        end else if (abort) begin
          abort_pend_next = 1'b1;
        end
      end
      DWELL: begin
        if (abort) begin
          state_next = IDLE;
        end else if (timer_expired) begin
          if (last_point) begin
            state_next = DONE;
          end else begin
            advance    = 1'b1;
            state_next = ISSUE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          state_next = IDLE;
        end else if (sh_loop_reg && (sh_num_reg != '0)) begin
          reload     = 1'b1;
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shadow configuration and sweep datapath
  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      sh_start_reg  <= '0;
      sh_delta_reg  <= '0;
      sh_num_reg    <= '0;
      sh_dwell_reg  <= '0;
      sh_loop_reg   <= 1'b0;
      step_reg      <= '0;
      point_idx_reg <= '0;
      dither_reg    <= 1'b0;
    end else if (load_cfg) begin
      sh_start_reg  <= cfg_start_step;
      sh_delta_reg  <= cfg_delta_step;
      sh_num_reg    <= cfg_num_points;
      sh_dwell_reg  <= cfg_dwell;
      sh_loop_reg   <= cfg_loop;
      step_reg      <= cfg_start_step;
      point_idx_reg <= '0;
      dither_reg    <= cfg_dither;
    end else if (reload) begin
      step_reg      <= sh_start_reg;
      point_idx_reg <= '0;
    end else if (advance) begin
      // Modulo 2^STEP_WIDTH; wrap-around is intended.
      step_reg      <= step_reg + sh_delta_reg;
      point_idx_reg <= point_idx_reg + NPTS_WIDTH'(1);
    end
  end

  // Outputs, decoded from registers only
  always_comb begin
    m_axis_step_tvalid = (state_reg == ISSUE);
    busy               = (state_reg != IDLE);
    done               = (state_reg == DONE);
    m_axis_step_tdata  = step_reg;
    point_idx          = point_idx_reg;
    dither_enable      = dither_reg;
  end

endmodule

// File: tb/tb_dsm_sweep_ctrl.sv
module tb_dsm_sweep_ctrl;

  localparam int SW = 32;
  localparam int DW = 16;
  localparam int NW = 12;

  logic          aclk = 1'b0;
  logic          arst_n = 1'b0;
  logic [SW-1:0] cfg_start_step = '0;
  logic [SW-1:0] cfg_delta_step = '0;
  logic [NW-1:0] cfg_num_points = '0;
  logic [DW-1:0] cfg_dwell = '0;
  logic          cfg_dither = 1'b0;
  logic          cfg_loop = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          dither_enable;
  logic          busy;
  logic          done;
  logic [NW-1:0] point_idx;

  dsm_sweep_ctrl dut (
    .aclk               (aclk),
    .arst_n             (arst_n),
    .cfg_start_step     (cfg_start_step),
    .cfg_delta_step     (cfg_delta_step),
    .cfg_num_points     (cfg_num_points),
    .cfg_dwell          (cfg_dwell),
    .cfg_dither         (cfg_dither),
    .cfg_loop           (cfg_loop),
    .start              (start),
    .abort              (abort),
    .m_axis_step_tdata  (tdata),
    .m_axis_step_tvalid (tvalid),
    .m_axis_step_tready (tready),
    .dither_enable      (dither_enable),
    .busy               (busy),
    .done               (done),
    .point_idx          (point_idx)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    bit          is_done;
    logic [SW-1:0] data;
    int          idx;
    bit          dith;
  } ev_t;

  ev_t exp_q[$];
  bit  rdy[256];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: pops the expected events due this cycle and compares them with
  // what the DUT presents; anything observed but not expected is an error.
  bit            prev_stall = 1'b0;
  logic [SW-1:0] prev_data = '0;
  logic [NW-1:0] prev_idx = '0;
  bit            obs_beat, obs_done;
  ev_t           mev;

  initial begin
    forever begin
      @(negedge aclk);
      if (!arst_n) begin
        prev_stall = 1'b0;
      end else begin
        obs_beat = tvalid && tready;
        obs_done = done;
        if (prev_stall) begin
          chk("hold_valid", 64'(tvalid), 64'(1));
          chk("hold_data", 64'(tdata), 64'(prev_data));
          chk("hold_idx", 64'(point_idx), 64'(prev_idx));
        end
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
        prev_idx   = point_idx;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          mev = exp_q.pop_front();
          if (mev.cyc != cyc) begin
            chk("event_time", 64'(cyc), 64'(mev.cyc));
          end else if (!mev.is_done) begin
            chk("beat_present", 64'(obs_beat), 64'(1));
            if (obs_beat) begin
              chk("beat_data", 64'(tdata), 64'(mev.data));
              chk("beat_idx", 64'(point_idx), 64'(NW'(mev.idx)));
              chk("beat_dither", 64'(dither_enable), 64'(mev.dith));
            end
            obs_beat = 1'b0;
          end else begin
            chk("done_present", 64'(obs_done), 64'(1));
            chk("busy_at_done", 64'(busy), 64'(1));
            chk("dither_at_done", 64'(dither_enable), 64'(mev.dith));
            obs_done = 1'b0;
          end
        end
        chk("no_extra_beat", 64'(obs_beat), 64'(0));
        chk("no_extra_done", 64'(obs_done), 64'(0));
      end
    end
  end

  // Reference timeline: point i is offered from cycle t, accepted at the first
  // ready cycle h >= t, the next point is offered at h+dwell+1, and done follows
  // the last acceptance by dwell+1 cycles. Steps are start + i*delta mod 2^32.
  // bp: 0 always ready, 1 random, 2 stall cycles 4..8, 3 stall cycles 3..6.
  task automatic run_sweep(input logic [SW-1:0] s, input logic [SW-1:0] d,
                           input int n, input int dw, input bit dith, input bit lp,
                           input int laps, input int abort_at, input int bp,
                           input bit scramble, input int reset_at);
    int base, t, h, endr;
    bit stop;
    logic [SW-1:0] step;
    ev_t ev;
    for (int c = 0; c < 256; c++) begin
      case (bp)
        1:       rdy[c] = (c >= 150) || ($urandom_range(0, 2) != 0);
        2:       rdy[c] = !(c >= 4 && c <= 8);
        3:       rdy[c] = !(c >= 3 && c <= 6);
        default: rdy[c] = 1'b1;
      endcase
    end
    @(posedge aclk);
    #1;
    base = cyc;
    stop = 1'b0;
    endr = 0;
    t = 1;
    ev.dith = dith;
    if (n == 0) begin
      ev.cyc = base + 1; ev.is_done = 1'b1; ev.data = '0; ev.idx = 0;
      exp_q.push_back(ev);
      endr = 2;
    end else begin
      for (int lap = 0; lap < laps && !stop; lap++) begin
        step = s;
        for (int i = 0; i < n && !stop; i++) begin
          h = t;
          while (h < 255 && !rdy[h]) h++;
          ev.cyc = base + h; ev.is_done = 1'b0; ev.data = step; ev.idx = i;
          exp_q.push_back(ev);
          if (abort_at >= t && abort_at <= h) begin
            endr = h + 1; stop = 1'b1;
          end else if (abort_at > h && abort_at <= h + dw) begin
            endr = abort_at + 1; stop = 1'b1;
          end
          step = step + d;
          t = h + dw + 1;
        end
        if (!stop) begin
          ev.cyc = base + t; ev.is_done = 1'b1; ev.data = '0; ev.idx = 0;
          exp_q.push_back(ev);
          if (abort_at == t || !lp) begin
            endr = t + 1; stop = 1'b1;
          end else begin
            t = t + 1;
          end
        end
      end
      if (!stop) endr = t;
    end

    cfg_start_step = s;
    cfg_delta_step = d;
    cfg_num_points = NW'(n);
    cfg_dwell      = DW'(dw);
    cfg_dither     = dith;
    cfg_loop       = lp;
    start          = 1'b1;
    abort          = 1'b0;
    tready         = rdy[0];

    for (int r = 1; r <= endr; r++) begin
      @(posedge aclk);
      #1;
      start  = scramble && (n > 0) && (r == 2);
      abort  = (r == abort_at);
      tready = rdy[r];
      if (scramble) begin
        cfg_start_step = $urandom;
        cfg_delta_step = $urandom;
        cfg_num_points = NW'($urandom_range(0, 7));
        cfg_dwell      = DW'($urandom_range(0, 5));
        cfg_dither     = 1'($urandom_range(0, 1));
        cfg_loop       = 1'($urandom_range(0, 1));
      end
      if (r == reset_at) begin
        #2;
        arst_n = 1'b0;
        #1;
        chk("rst_tvalid", 64'(tvalid), 64'(0));
        chk("rst_tdata", 64'(tdata), 64'(0));
        chk("rst_dither", 64'(dither_enable), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_idx", 64'(point_idx), 64'(0));
        exp_q.delete();
        @(posedge aclk);
        #1;
        arst_n = 1'b1;
        abort  = 1'b0;
        tready = 1'b1;
        start  = 1'b0;
        return;
      end
    end
    @(negedge aclk);
    chk("end_busy", 64'(busy), 64'(0));
    chk("end_tvalid", 64'(tvalid), 64'(0));
    chk("end_dither", 64'(dither_enable), 64'(dith));
    abort  = 1'b0;
    start  = 1'b0;
    tready = 1'b1;
    repeat (2) @(posedge aclk);
  endtask

  initial begin
    #2;
    chk("por_tvalid", 64'(tvalid), 64'(0));
    chk("por_busy", 64'(busy), 64'(0));
    chk("por_done", 64'(done), 64'(0));
    chk("por_tdata", 64'(tdata), 64'(0));
    chk("por_dither", 64'(dither_enable), 64'(0));
    chk("por_idx", 64'(point_idx), 64'(0));
    repeat (3) @(posedge aclk);
    #1;
    arst_n = 1'b1;
    tready = 1'b1;
    repeat (2) @(posedge aclk);

    // basic sweep: beats at cycles 1/4/7, done at 10
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 2, 1'b1, 1'b0, 1, -1, 0, 1'b0, -1);
    // backpressure on the second beat
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 2, 1'b0, 1'b0, 1, -1, 2, 1'b0, -1);
    // wrap-around and negative delta
    run_sweep(32'hFFFF_FFF0, 32'h0000_0020, 2, 1, 1'b1, 1'b0, 1, -1, 0, 1'b0, -1);
    run_sweep(32'h0000_0100, 32'hFFFF_FFC0, 2, 1, 1'b0, 1'b0, 1, -1, 0, 1'b0, -1);
    // empty sweep and zero dwell
    run_sweep(32'h1234_5678, 32'h0000_0001, 0, 3, 1'b1, 1'b0, 1, -1, 0, 1'b0, -1);
    run_sweep(32'h0000_1000, 32'h0000_0100, 4, 0, 1'b0, 1'b0, 1, -1, 0, 1'b0, -1);
    // looping sweep A,B,A,B,A then abort in dwell
    run_sweep(32'hAAAA_0000, 32'h0000_5555, 2, 1, 1'b1, 1'b1, 3, 12, 0, 1'b0, -1);
    // abort in dwell, abort while a beat is stalled
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 2, 1'b0, 1'b0, 1, 5, 0, 1'b0, -1);
    run_sweep(32'h0200_0000, 32'h0000_0010, 3, 1, 1'b1, 1'b0, 1, 3, 3, 1'b0, -1);

    // start and abort together in idle: nothing happens
    @(posedge aclk);
    #1;
    cfg_num_points = NW'(3);
    cfg_dither     = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(posedge aclk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge aclk);
      chk("start_abort_busy", 64'(busy), 64'(0));
      chk("start_abort_dither", 64'(dither_enable), 64'(1));
    end

    // reset during dwell, then a clean basic sweep
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 2, 1'b1, 1'b0, 1, -1, 0, 1'b0, 5);
    repeat (2) @(posedge aclk);
    run_sweep(32'h0100_0000, 32'h0010_0000, 3, 2, 1'b0, 1'b0, 1, -1, 0, 1'b0, -1);

    // randomized sweeps with backpressure and cfg churn while busy
    for (int k = 0; k < 12; k++) begin
      run_sweep($urandom, $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), 1'b0, 1, -1, 1, 1'b1, -1);
    end

    @(negedge aclk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsm_sweep_ctrl.md
# dsm_sweep_ctrl

Programmable frequency-sweep sequencer that drives the NCO step input of the DSM transmit chain. It issues a list of `nco_step` values (start, start+delta, …) as AXI-stream-style beats into the I/Q NCO pair. It holds each point for a programmed dwell time and owns the chain's `dither_enable`. The block sits between the control/register side and the DSM core, replacing static `nco_step` / `nco_step_enable` tie-offs.

## Interface
Parameters:
- `STEP_WIDTH`, 32, NCO step width (ACC_FRAC_WIDTH+ACC_INT_WIDTH).
- `DWELL_WIDTH`, 16, dwell counter width.
- `NPTS_WIDTH`, 12, point-count width.

Ports:
- `aclk`  in  1  sole clock; single clock domain.
- `arst_n`  in  1  asynchronous, active-low reset.
- `cfg_start_step`  in  STEP_WIDTH  first step value, unsigned.
- `cfg_delta_step`  in  STEP_WIDTH  per-point increment, two's complement.
- `cfg_num_points`  in  NPTS_WIDTH  number of points; 0 = empty sweep.
- `cfg_dwell`  in  DWELL_WIDTH  idle cycles after each accepted beat.
- `cfg_dither`  in  1  dither setting applied for the sweep.
- `cfg_loop`  in  1  restart from the start step after the last point.
- `start`  in  1  level-sampled start request.
- `abort`  in  1  level-sampled stop request.
- `m_axis_step_tdata`  out  STEP_WIDTH  step to the NCOs.
- `m_axis_step_tvalid`  out  1  beat valid.
- `m_axis_step_tready`  in  1  NCO ready.
- `dither_enable`  out  1  to both NCOs.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse at sweep completion.
- `point_idx`  out  NPTS_WIDTH  index of the current point.

## Operation
- FSM states: IDLE, ISSUE, DWELL, DONE.
- IDLE:
  - `start`=1 and `abort`=0 latches all `cfg_*` into shadow registers.
  - Sets step=start, `point_idx`=0, `dither_enable`=`cfg_dither`.
  - Goes to ISSUE, or to DONE if `cfg_num_points`=0.
  - `start` and `abort` high together in IDLE: abort wins, state stays IDLE.
- ISSUE:
  - `tvalid`=1 and `tdata`=the current step, both held stable until `tready`.
  - On handshake: go to DWELL with counter=`cfg_dwell`. If `cfg_dwell`=0, skip DWELL and take the DWELL-exit path immediately.
- DWELL:
  - Counter decrements each cycle.
  - On expiry: if `point_idx`=N−1, go to DONE. Otherwise step+=delta, `point_idx`+=1, go to ISSUE.
- DONE:
  - `done`=1 for one cycle.
  - Then go to ISSUE with step reloaded to start and `point_idx`=0 if the shadow loop bit is set and N>0. Otherwise go to IDLE.
- Arithmetic: step update is modulo 2^STEP_WIDTH. Wrap-around is legal, with no saturation and no flag.
- `abort` is evaluated in ISSUE, DWELL and DONE:
  - In DWELL or DONE: go to IDLE on the next edge, with no `done` pulse.
  - In ISSUE: `tvalid` is never dropped without a handshake. The current beat completes, then the FSM goes to IDLE with no `done` pulse.
- `start` while busy is ignored. `cfg_*` changes while busy have no effect, because only the shadow copies are used.
- `dither_enable` changes only on an accepted start. It holds its value through IDLE.

## Timing
- Reset values: `tvalid`=0, `tdata`=0, `dither_enable`=0, `busy`=0, `done`=0, `point_idx`=0, state IDLE.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous).
- Latency: `start` sampled at edge 0 → `tvalid`=1 in cycle 1.
- With `tready` held at 1, the spacing between beat handshakes is `cfg_dwell`+1 cycles.
- `done` is asserted `cfg_dwell`+1 cycles after the last handshake.
- Empty sweep (`cfg_num_points`=0): `done` in cycle 1, no beat issued.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Package `dsm_ctrl_pkg` holds:
  - the `sweep_state_t` enum (IDLE/ISSUE/DWELL/DONE);
  - default width localparams (32/16/12) shared with `dsm_core` instantiation.
- Sub-module `dsm_dwell_timer`: loadable down-counter with a `load`/`expired` interface. It is reused later for burst gating.

## Test plan
- Basic sweep: start=0x0100_0000, delta=0x0010_0000, N=3, dwell=2, `tready`=1, start at edge 0 → beats 0x0100_0000, 0x0110_0000, 0x0120_0000 in cycles 1/4/7; `done` in cycle 10; then IDLE.
- Backpressure: `tready`=0 for 5 cycles during beat 2 → `tdata`/`tvalid` stable throughout; spacing after release unchanged; `point_idx`=1 until the handshake.
- Wrap and negative delta: start=0xFFFF_FFF0, delta=0x20 → second beat 0x0000_0010. Separately, start=0x100, delta=0xFFFF_FFC0 → second beat 0x0C0.
- Edge configs:
  - N=0 → `done` in cycle 1, no `tvalid`.
  - dwell=0, N=4 → beats on 4 consecutive cycles.
  - `cfg_loop`=1, N=2 → beat sequence A, B, A, B…
- Abort:
  - Abort in DWELL → IDLE next edge, no `done`, no further beats.
  - Abort in ISSUE with `tready`=0 → `tvalid` held until `tready`, then IDLE.
  - `start`+`abort` together in IDLE → no sweep.
- Reset mid-DWELL: `arst_n` low asynchronously → all outputs 0 immediately. After release, a new start behaves exactly as in the basic-sweep scenario.
